// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared enums for the pipeline controller (forward select, memory FSM state)
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_M = 2'b01, FWD_W = 2'b10} fwd_sel_t;
    typedef enum logic [1:0] {MS_IDLE = 2'b00, MS_WAIT = 2'b01, MS_ABORT = 2'b10} mem_state_t;
endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// hazard_cmp: per-operand execute forward select and decode RAW matches; register 0 never matches
module hazard_cmp
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b0
) (
    input  logic [REG_AW-1:0] i_e_src,
    input  logic [REG_AW-1:0] i_d_src,
    input  logic              i_d_use,
    input  logic [REG_AW-1:0] i_e_wa,
    input  logic              i_e_we,
    input  logic [REG_AW-1:0] i_m_wa,
    input  logic              i_m_we,
    input  logic [REG_AW-1:0] i_w_wa,
    input  logic              i_w_we,
    output fwd_sel_t          o_fwd,
    output logic              o_hit_e,
    output logic              o_hit_m
);
    logic w_e_src_nz;
    logic w_d_src_ok;

    assign w_e_src_nz = i_e_src != '0;
    assign w_d_src_ok = i_d_use && i_d_src != '0;
    assign o_fwd = (!FWD_EN || !w_e_src_nz) ? FWD_RF
                 : (i_m_we && i_m_wa == i_e_src) ? FWD_M
                 : (i_w_we && i_w_wa == i_e_src) ? FWD_W
                 : FWD_RF;
    assign o_hit_e = w_d_src_ok && i_e_we && i_e_wa == i_d_src;
    assign o_hit_m = w_d_src_ok && i_m_we && i_m_wa == i_d_src;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard detection, operand forwarding, data-memory wait/abort and fetch flush control.
// Define PIPE_CTRL_FWD_EN to build with execute forwarding (load-use stalls only);
// without it, operands always come from the regfile and any E/M RAW hazard stalls decode.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic [REG_AW-1:0] e_rs,
    input  logic [REG_AW-1:0] e_rt,
    input  logic [REG_AW-1:0] e_wa,
    input  logic              e_we,
    input  logic              e_is_load,
    input  logic [REG_AW-1:0] m_wa,
    input  logic              m_we,
    input  logic [REG_AW-1:0] w_wa,
    input  logic              w_we,
    input  logic              d_redirect,
    input  logic              m_mem_req,
    input  logic              dmem_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              bubble_e,
    output logic              flush_d,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt
);
`ifdef PIPE_CTRL_FWD_EN
    localparam bit L_FWD_EN = 1'b1;
`else
    localparam bit L_FWD_EN = 1'b0;
`endif
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    mem_state_t       r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_mem_err;
    logic             r_pend;
    logic [CNT_W-1:0] r_stall_cnt;
    fwd_sel_t         w_fwd_a, w_fwd_b;
    logic             w_hit_e_a, w_hit_e_b, w_hit_m_a, w_hit_m_b;
    logic             w_load_use, w_raw, w_abort, w_mem_stall, w_hazard, w_stall_d, w_timeout;

    hazard_cmp #(.REG_AW(REG_AW), .FWD_EN(L_FWD_EN)) u_cmp_a (
        .i_e_src(e_rs), .i_d_src(d_rs), .i_d_use(d_use_rs),
        .i_e_wa(e_wa), .i_e_we(e_we), .i_m_wa(m_wa), .i_m_we(m_we),
        .i_w_wa(w_wa), .i_w_we(w_we),
        .o_fwd(w_fwd_a), .o_hit_e(w_hit_e_a), .o_hit_m(w_hit_m_a)
    );

    hazard_cmp #(.REG_AW(REG_AW), .FWD_EN(L_FWD_EN)) u_cmp_b (
        .i_e_src(e_rt), .i_d_src(d_rt), .i_d_use(d_use_rt),
        .i_e_wa(e_wa), .i_e_we(e_we), .i_m_wa(m_wa), .i_m_we(m_we),
        .i_w_wa(w_wa), .i_w_we(w_we),
        .o_fwd(w_fwd_b), .o_hit_e(w_hit_e_b), .o_hit_m(w_hit_m_b)
    );

    assign w_load_use  = e_is_load && (w_hit_e_a || w_hit_e_b);
    assign w_raw       = w_hit_e_a || w_hit_e_b || w_hit_m_a || w_hit_m_b;
    assign w_abort     = r_state == MS_ABORT;
    assign w_mem_stall = (r_state == MS_IDLE && m_mem_req && !dmem_ready) ||
                         (r_state == MS_WAIT && !dmem_ready);
    assign w_hazard    = !w_abort && (L_FWD_EN ? w_load_use : w_raw);
    assign w_stall_d   = w_mem_stall || w_hazard;
    assign w_timeout   = r_wait_cnt == WC_W'(MEM_TIMEOUT - 1);

    assign stall_f   = w_stall_d;
    assign stall_d   = w_stall_d;
    assign stall_e   = w_mem_stall;
    assign stall_m   = w_mem_stall;
    assign bubble_e  = w_hazard && !w_mem_stall;
    assign flush_d   = (d_redirect || r_pend) && !w_stall_d;
    assign fwd_a     = w_fwd_a;
    assign fwd_b     = w_fwd_b;
    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;

    // Memory wait FSM: counts WAIT cycles and aborts with a one-cycle error pulse on timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= MS_IDLE;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_mem_err <= 1'b0;
            case (r_state)
                MS_IDLE: begin
                    if (m_mem_req && !dmem_ready) begin
                        r_state    <= MS_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                MS_WAIT: begin
                    if (dmem_ready) begin
                        r_state <= MS_IDLE;
                    end else if (w_timeout) begin
                        r_state   <= MS_ABORT;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= MS_IDLE;
            endcase
        end
    end

    // Hold a redirect seen under a stall until the first free cycle; count stalled fetch cycles, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend      <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_pend <= (d_redirect || r_pend) && w_stall_d;
            if (w_stall_d && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table, directed multi-cycle sequences and a randomized run against a reference model
module tb_pipe_ctrl;
    localparam int AW = 5;
    localparam int TO = 15;
    localparam int CW = 5;
`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0] d_rs, d_rt, e_rs, e_rt, e_wa, m_wa, w_wa;
    logic d_use_rs, d_use_rt, e_we, e_is_load, m_we, w_we, d_redirect, m_mem_req, dmem_ready;
    logic stall_f, stall_d, stall_e, stall_m, bubble_e, flush_d, mem_err;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .e_rs(e_rs), .e_rt(e_rt), .e_wa(e_wa), .e_we(e_we), .e_is_load(e_is_load),
        .m_wa(m_wa), .m_we(m_we), .w_wa(w_wa), .w_we(w_we),
        .d_redirect(d_redirect), .m_mem_req(m_mem_req), .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .bubble_e(bubble_e), .flush_d(flush_d), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [AW-1:0] d_rs, d_rt;
        bit u_rs, u_rt;
        logic [AW-1:0] e_rs, e_rt, e_wa;
        bit e_we, ld;
        logic [AW-1:0] m_wa;
        bit m_we;
        logic [AW-1:0] w_wa;
        bit w_we;
        int fa, fb;
        bit lu, raw;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        {d_rs, d_rt, e_rs, e_rt, e_wa, m_wa, w_wa} = '0;
        {d_use_rs, d_use_rt, e_we, e_is_load, m_we, w_we, d_redirect, m_mem_req, dmem_ready} = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        tick();
        reset = 1'b0;
    endtask

    task automatic add(input int drs, drt, urs, urt, ers, ert, ewa, ewe, eld, mwa, mwe, wwa, wwe,
                       input int fa, fb, lu, raw);
        vec_t v;
        v.d_rs = AW'(drs); v.d_rt = AW'(drt); v.u_rs = urs != 0; v.u_rt = urt != 0;
        v.e_rs = AW'(ers); v.e_rt = AW'(ert); v.e_wa = AW'(ewa); v.e_we = ewe != 0; v.ld = eld != 0;
        v.m_wa = AW'(mwa); v.m_we = mwe != 0; v.w_wa = AW'(wwa); v.w_we = wwe != 0;
        v.fa = fa; v.fb = fb; v.lu = lu != 0; v.raw = raw != 0;
        tbl.push_back(v);
    endtask

    function automatic int outs();
        return int'({stall_f, stall_d, stall_e, stall_m, bubble_e, flush_d, fwd_a, fwd_b, mem_err});
    endfunction

    function automatic int fsel(input logic [AW-1:0] src);
        if (!FWD || src == 0) return 0;
        if (m_we && m_wa == src) return 1;
        if (w_we && w_wa == src) return 2;
        return 0;
    endfunction

    function automatic bit dhit(input logic [AW-1:0] src, input logic use_src, input logic [AW-1:0] wa, input logic we);
        return use_src && src != 0 && we && wa == src;
    endfunction

    task automatic run_timeout(input string tag, input int exp_cnt);
        int stalls = 0;
        int seen = -1;
        m_mem_req = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 0; c < 40 && seen < 0; c++) begin
            #1;
            if (mem_err) begin
                seen = c;
                chk({tag, "_abort_stall"}, int'(stall_f), 0);
                m_mem_req = 1'b0;
            end else if (stall_f) begin
                stalls++;
            end
            tick();
        end
        #1;
        chk({tag, "_err_seen"}, int'(seen >= 0), 1);
        chk({tag, "_stall_cycles"}, stalls, TO + 1);
        chk({tag, "_err_pulse"}, int'(mem_err), 0);
        chk({tag, "_idle"}, int'(stall_f), 0);
        chk({tag, "_cnt"}, int'(stall_cnt), exp_cnt);
    endtask

    task automatic run_random(input int n);
        int run = 0;
        int scnt = 0;
        bit ab = 1'b0;
        bit pend = 1'b0;
        bit mstall, hz, sf, bub, fl, lu, raw;
        logic [10:0] ev;
        for (int c = 0; c < n; c++) begin
            tick();
            d_rs = AW'($urandom_range(0, 3)); d_rt = AW'($urandom_range(0, 3));
            e_rs = AW'($urandom_range(0, 3)); e_rt = AW'($urandom_range(0, 3));
            e_wa = AW'($urandom_range(0, 3)); m_wa = AW'($urandom_range(0, 3));
            w_wa = AW'($urandom_range(0, 3));
            d_use_rs = 1'($urandom_range(0, 1)); d_use_rt = 1'($urandom_range(0, 1));
            e_we = 1'($urandom_range(0, 1)); m_we = 1'($urandom_range(0, 1)); w_we = 1'($urandom_range(0, 1));
            e_is_load = $urandom_range(0, 2) == 0;
            d_redirect = $urandom_range(0, 4) == 0;
            m_mem_req = $urandom_range(0, 3) == 0;
            dmem_ready = ((c / 60) % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            #1;
            lu = e_is_load && (dhit(d_rs, d_use_rs, e_wa, e_we) || dhit(d_rt, d_use_rt, e_wa, e_we));
            raw = dhit(d_rs, d_use_rs, e_wa, e_we) || dhit(d_rt, d_use_rt, e_wa, e_we) ||
                  dhit(d_rs, d_use_rs, m_wa, m_we) || dhit(d_rt, d_use_rt, m_wa, m_we);
            mstall = !ab && (run > 0 ? !dmem_ready : (m_mem_req && !dmem_ready));
            hz = !ab && (FWD ? lu : raw);
            sf = mstall || hz;
            bub = hz && !mstall;
            fl = (d_redirect || pend) && !sf;
            ev = {sf, sf, mstall, mstall, bub, fl, 2'(fsel(e_rs)), 2'(fsel(e_rt)), ab};
            chk($sformatf("rnd%0d_outs", c), outs(), int'(ev));
            chk($sformatf("rnd%0d_cnt", c), int'(stall_cnt), scnt);
            pend = (d_redirect || pend) && sf;
            if (sf && scnt < (1 << CW) - 1) scnt++;
            if (ab) begin
                ab = 1'b0;
                run = 0;
            end else if (mstall) begin
                run++;
                if (run == TO + 1) begin
                    ab = 1'b1;
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_seen;
        clear_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_outs", outs(), 0);
        chk("rst_cnt", int'(stall_cnt), 0);

        add(0,0,0,0, 5,0, 0,0,0, 5,1, 5,1, 1,0,0,0);
        add(0,0,0,0, 0,0, 0,0,0, 0,1, 0,1, 0,0,0,0);
        add(0,0,0,0, 7,7, 0,0,0, 0,0, 7,1, 2,2,0,0);
        add(0,0,0,0, 3,4, 0,0,0, 3,0, 4,1, 0,2,0,0);
        add(0,0,0,0, 9,9, 0,0,0, 9,1, 9,1, 1,1,0,0);
        add(8,0,1,0, 0,0, 8,1,1, 0,0, 0,0, 0,0,1,1);
        add(8,8,0,1, 0,0, 8,1,1, 0,0, 0,0, 0,0,1,1);
        add(8,0,0,0, 0,0, 8,1,1, 0,0, 0,0, 0,0,0,0);
        add(0,0,1,1, 0,0, 0,1,1, 0,0, 0,0, 0,0,0,0);
        add(8,0,1,0, 0,0, 8,1,0, 0,0, 0,0, 0,0,0,1);
        add(8,0,1,0, 0,0, 8,0,1, 0,0, 0,0, 0,0,0,0);
        add(0,6,0,1, 0,6, 0,0,0, 6,1, 0,0, 0,1,0,1);
        add(6,0,1,0, 0,0, 0,0,0, 0,0, 6,1, 0,0,0,0);
        add(0,0,1,1, 0,0, 0,0,0, 0,1, 0,0, 0,0,0,0);
        foreach (tbl[i]) begin
            tick();
            d_rs = tbl[i].d_rs; d_rt = tbl[i].d_rt; d_use_rs = tbl[i].u_rs; d_use_rt = tbl[i].u_rt;
            e_rs = tbl[i].e_rs; e_rt = tbl[i].e_rt; e_wa = tbl[i].e_wa; e_we = tbl[i].e_we;
            e_is_load = tbl[i].ld; m_wa = tbl[i].m_wa; m_we = tbl[i].m_we; w_wa = tbl[i].w_wa; w_we = tbl[i].w_we;
            #1;
            chk($sformatf("vec%0d_fwd_a", i), int'(fwd_a), FWD ? tbl[i].fa : 0);
            chk($sformatf("vec%0d_fwd_b", i), int'(fwd_b), FWD ? tbl[i].fb : 0);
            chk($sformatf("vec%0d_stall", i), int'({stall_f, stall_d, bubble_e, stall_e}),
                (FWD ? tbl[i].lu : tbl[i].raw) ? 14 : 0);
        end

        do_reset();
        e_is_load = 1'b1; e_we = 1'b1; e_wa = 8; d_rs = 8; d_use_rs = 1'b1;
        #1;
        chk("lu_stall", int'({stall_f, stall_d, bubble_e, stall_e}), 14);
        tick();
        e_is_load = 1'b0; e_we = 1'b0; e_wa = 0; m_we = 1'b1; m_wa = 8;
        #1;
        chk("lu_next", int'({stall_f, stall_d, bubble_e}), FWD ? 0 : 7);
        tick();
        m_we = 1'b0; w_we = 1'b1; w_wa = 8;
        #1;
        chk("lu_done", int'({stall_f, stall_d, bubble_e}), 0);
        chk("lu_cnt", int'(stall_cnt), FWD ? 1 : 2);

        do_reset();
        m_mem_req = 1'b1;
        #1;
        chk("mem_stall0", int'({stall_f, stall_d, stall_e, stall_m, bubble_e}), 30);
        for (int i = 1; i < 3; i++) begin
            tick();
            if (i == 2) begin
                e_is_load = 1'b1; e_we = 1'b1; e_wa = 4; d_rs = 4; d_use_rs = 1'b1;
            end
            #1;
            chk($sformatf("mem_stall%0d", i), int'({stall_f, stall_d, stall_e, stall_m, bubble_e}), 30);
        end
        tick();
        clear_in();
        m_mem_req = 1'b1; dmem_ready = 1'b1;
        #1;
        chk("mem_release", int'({stall_f, stall_d, stall_e, stall_m, bubble_e}), 0);
        tick();
        m_mem_req = 1'b0; dmem_ready = 1'b0;
        #1;
        chk("mem_cnt", int'(stall_cnt), 3);
        chk("mem_idle", int'({stall_f, stall_e, mem_err}), 0);

        do_reset();
        run_timeout("to1", 16);
        run_timeout("to2", (1 << CW) - 1);

        do_reset();
        m_mem_req = 1'b1; d_redirect = 1'b1;
        #1;
        chk("rd_hold0", int'(flush_d), 0);
        tick();
        d_redirect = 1'b0;
        #1;
        chk("rd_hold1", int'(flush_d), 0);
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("rd_flush", int'(flush_d), 1);
        tick();
        m_mem_req = 1'b0; dmem_ready = 1'b0;
        #1;
        chk("rd_once", int'(flush_d), 0);
        tick();
        d_redirect = 1'b1;
        #1;
        chk("rd_direct", int'(flush_d), 1);
        tick();
        d_redirect = 1'b0;
        #1;
        chk("rd_direct_clr", int'(flush_d), 0);
        tick();
        e_is_load = 1'b1; e_we = 1'b1; e_wa = 3; d_rt = 3; d_use_rt = 1'b1; d_redirect = 1'b1;
        #1;
        chk("lu_rd_hold", int'({flush_d, bubble_e}), 1);
        tick();
        clear_in();
        #1;
        chk("lu_rd_flush", int'({flush_d, bubble_e}), 2);
        tick();
        #1;
        chk("lu_rd_clr", int'(flush_d), 0);

        do_reset();
        m_mem_req = 1'b1;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_in();
        #1;
        chk("rstw_cnt", int'(stall_cnt), 0);
        chk("rstw_stall", int'(stall_f), 0);
        err_seen = 0;
        repeat (20) begin
            tick();
            if (mem_err) err_seen++;
        end
        chk("rstw_noerr", err_seen, 0);

        do_reset();
        run_random(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum data-memory wait cycles before abort.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk input 1 system clock; reset input 1 synchronous active-high reset.
REQ-005 SHALL have ports: d_rs, d_rt input REG_AW, decode source registers; d_use_rs, d_use_rt input 1, decode source valid.
REQ-006 SHALL have ports: e_rs, e_rt input REG_AW, execute source registers; e_wa input REG_AW, e_we input 1, e_is_load input 1, execute writer.
REQ-007 SHALL have ports: m_wa input REG_AW, m_we input 1, memory writer; w_wa input REG_AW, w_we input 1, writeback writer.
REQ-008 SHALL have ports: d_redirect input 1, taken branch or jump resolved in decode; m_mem_req input 1, memory-stage access valid; dmem_ready input 1, data memory done.
REQ-009 SHALL have ports: stall_f, stall_d, stall_e, stall_m output 1, hold stage register; bubble_e output 1, insert NOP into execute; flush_d output 1, kill fetched instruction.
REQ-010 SHALL have ports: fwd_a, fwd_b output 2, execute operand select (00 regfile, 01 M result, 10 W result); mem_err output 1, timeout pulse; stall_cnt output CNT_W, stall-cycle count.

Function
REQ-011 SHALL set fwd_a to 01 when m_we, m_wa==e_rs, e_rs!=0; else 10 when w_we, w_wa==e_rs, e_rs!=0; else 00; fwd_b likewise with e_rt; M beats W.
REQ-012 SHALL detect load-use when e_is_load, e_we, e_wa!=0 and e_wa matches d_rs (d_use_rs) or d_rt (d_use_rt); response: stall_f=stall_d=1, bubble_e=1 for exactly one cycle.
REQ-013 SHALL run memory FSM IDLE/WAIT/ABORT: IDLE->WAIT when m_mem_req & !dmem_ready; WAIT->IDLE when dmem_ready; WAIT->ABORT when wait count reaches MEM_TIMEOUT; ABORT->IDLE unconditionally next cycle.
REQ-014 SHALL assert stall_f, stall_d, stall_e, stall_m combinationally while m_mem_req & !dmem_ready in IDLE and throughout WAIT; memory stall overrides load-use (bubble_e=0 while memory stall).
REQ-015 SHALL pulse mem_err for one cycle in ABORT, release all stalls in ABORT, and clear wait count on entering WAIT.
REQ-016 SHALL assert flush_d one cycle when d_redirect and no stall_d; if d_redirect arrives during any stall, SHALL latch a pending flag and assert flush_d in the first unstalled cycle, then clear it.
REQ-017 SHALL never assert flush_d and bubble_e for the same decode instruction due to a single redirect; load-use stall delays the flush per REQ-016.
REQ-018 SHALL increment stall_cnt every cycle stall_f=1, saturating at all ones.
REQ-019 SHALL never treat register 0 as a hazard source.

Reset
REQ-020 SHALL on reset set FSM to IDLE, wait count 0, pending flag 0, stall_cnt 0, mem_err 0; combinational stall/flush outputs follow inputs from the following cycle.
REQ-021 SHALL, on reset asserted mid-WAIT, abandon the wait without asserting mem_err.

Configuration
REQ-022 SHALL compile forwarding in when PIPE_CTRL_FWD_EN is defined: behaviour per REQ-011/REQ-012.
REQ-023 SHALL without PIPE_CTRL_FWD_EN drive fwd_a=fwd_b=00 and stall D (stall_f, stall_d, bubble_e) while any enabled decode source matches a non-zero e_wa (e_we) or m_wa (m_we).

Structure
REQ-024 SHALL place fwd_sel_t enum (FWD_RF, FWD_M, FWD_W) and mem_state_t enum in the shared pipes package.
REQ-025 SHALL implement forwarding/RAW comparison in one sub-module named hazard_cmp, instantiated per operand.

Verification
REQ-026 SHALL test: m_we=1, m_wa=5, w_we=1, w_wa=5, e_rs=5 -> fwd_a=01; e_rs=0 with m_wa=0 -> fwd_a=00.
REQ-027 SHALL test: e_is_load=1, e_wa=8, d_rs=8, d_use_rs=1 -> one cycle stall_f=stall_d=bubble_e=1, then 0.
REQ-028 SHALL test: m_mem_req=1, dmem_ready low 3 cycles -> four stalls for 3 cycles, released on ready, stall_cnt=3.
REQ-029 SHALL test: dmem_ready never asserted, MEM_TIMEOUT=15 -> mem_err single pulse after 15 WAIT cycles, FSM back to IDLE.
REQ-030 SHALL test: d_redirect during memory stall -> flush_d exactly once in first unstalled cycle; reset mid-WAIT -> no mem_err, stall_cnt=0.
